// File: rtl/bsg_mul_acc_pkg.sv
// -----------------------------------------------------------------------------
// bsg_mul_acc_pkg
//   Shared definitions for the multiply-accumulate tail (bsg_mul_accumulate).
//   - state_e     : sequence FSM state (IDLE = no open sequence, ACCUM = partial
//                   sum in progress)
//   - acc_width() : accumulator width derived from operand width and guard bits
// -----------------------------------------------------------------------------
package bsg_mul_acc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    // Products are 2*width bits; guard bits absorb growth before overflow.
    function automatic int acc_width(input int width, input int guard);
        return 2 * width + guard;
    endfunction

endpackage

// File: rtl/bsg_mul_acc_add_sat.sv
// -----------------------------------------------------------------------------
// bsg_mul_acc_add_sat
//   Combinational datapath for one accumulate step: extends the product to the
//   accumulator width, adds it to the running sum, detects overflow and
//   (optionally) clamps the result.
//   Ports:
//     a          in   acc_width_p   running sum (zero on the first beat)
//     b          in   prod_width_p  raw product
//     is_signed  in   1             1: two's complement, 0: unsigned
//     b_ext      out  acc_width_p   extended product
//     sum        out  acc_width_p   a + b_ext, clamped when saturating
//     ovf        out  1             this addition overflowed
//   acc_width_p must exceed prod_width_p (at least one guard bit).
// -----------------------------------------------------------------------------
module bsg_mul_acc_add_sat #(
    parameter int prod_width_p = 16,
    parameter int acc_width_p  = 20,
    parameter int saturate_p   = 1
) (
    input  logic [acc_width_p-1:0]  a,
    input  logic [prod_width_p-1:0] b,
    input  logic                    is_signed,
    output logic [acc_width_p-1:0]  b_ext,
    output logic [acc_width_p-1:0]  sum,
    output logic                    ovf
);

    localparam int msb_lp = acc_width_p - 1;

    logic [acc_width_p-1:0] raw;
    logic [acc_width_p-1:0] sat_val;
    logic                   carry;
    logic                   ovf_signed;

    assign b_ext = is_signed
                 ? {{(acc_width_p - prod_width_p){b[prod_width_p-1]}}, b}
                 : {{(acc_width_p - prod_width_p){1'b0}}, b};

    assign {carry, raw} = {1'b0, a} + {1'b0, b_ext};

    // Signed overflow: both addends share a sign the result does not.
    assign ovf_signed = (a[msb_lp] == b_ext[msb_lp]) && (raw[msb_lp] != a[msb_lp]);
    assign ovf        = is_signed ? ovf_signed : carry;

    // On signed overflow the addends' common sign picks the clamp direction.
    assign sat_val = !is_signed ? {acc_width_p{1'b1}}
                   : a[msb_lp]  ? {1'b1, {(acc_width_p - 1){1'b0}}}
                   :              {1'b0, {(acc_width_p - 1){1'b1}}};

    assign sum = ((saturate_p != 0) && ovf) ? sat_val : raw;

endmodule

// File: rtl/bsg_mul_accumulate.sv
// -----------------------------------------------------------------------------
// bsg_mul_accumulate
//   Sums framed sequences of products from bsg_mul_pipelined into a wide
//   accumulator and publishes one result per sequence through an output
//   register with a v_o/yumi_i handshake.
//   Ports:
//     clk_i       in   1                  clock (rising edge)
//     reset_i     in   1                  asynchronous active-high reset
//     v_i         in   1                  product valid
//     ready_o     out  1                  product accepted this cycle (to en_i)
//     prod_i      in   2*width_p          product
//     signed_i    in   1                  signed sequence (first beat only)
//     first_i     in   1                  beat starts a new sequence
//     last_i      in   1                  beat ends the sequence
//     v_o         out  1                  result valid
//     data_o      out  2*width_p+guard_p  accumulated sum
//     overflow_o  out  1                  sequence overflowed (sticky)
//     count_o     out  count_width_p      terms in sequence (saturating)
//     yumi_i      in   1                  consumer takes result
// -----------------------------------------------------------------------------
module bsg_mul_accumulate
    import bsg_mul_acc_pkg::*;
#(
    parameter int width_p       = 64,
    parameter int guard_p       = 8,
    parameter int saturate_p    = 1,
    parameter int count_width_p = 16
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic                                      v_i,
    output logic                                      ready_o,
    input  logic [2*width_p-1:0]                      prod_i,
    input  logic                                      signed_i,
    input  logic                                      first_i,
    input  logic                                      last_i,
    output logic                                      v_o,
    output logic [acc_width(width_p, guard_p)-1:0]    data_o,
    output logic                                      overflow_o,
    output logic [count_width_p-1:0]                  count_o,
    input  logic                                      yumi_i
);

    localparam int acc_w_lp = acc_width(width_p, guard_p);

    state_e                   state_r;
    logic [acc_w_lp-1:0]      sum_r;
    logic [count_width_p-1:0] count_r;
    logic                     ovf_r;
    logic                     signed_r;

    logic                     accept;
    logic                     is_first;
    logic                     mode;
    logic [acc_w_lp-1:0]      add_a;
    logic [acc_w_lp-1:0]      add_ext;
    logic [acc_w_lp-1:0]      add_sum;
    logic                     add_ovf;
    logic                     ovf_next;
    logic [count_width_p-1:0] count_next;

    // A pending result may be replaced in the same cycle it is consumed,
    // so upstream sees no bubble on back-to-back sequences.
    assign ready_o  = ~v_o | yumi_i;
    assign accept   = v_i & ready_o;

    // Any beat accepted with no open sequence starts one.
    assign is_first = (state_r == IDLE) | first_i;
    assign mode     = is_first ? signed_i : signed_r;
    assign add_a    = is_first ? '0 : sum_r;

    assign ovf_next   = add_ovf | (~is_first & ovf_r);
    assign count_next = is_first  ? count_width_p'(1)
                      : &count_r  ? count_r
                      :             count_r + 1'b1;

    bsg_mul_acc_add_sat #(
        .prod_width_p (2 * width_p),
        .acc_width_p  (acc_w_lp),
        .saturate_p   (saturate_p)
    ) add_sat (
        .a         (add_a),
        .b         (prod_i),
        .is_signed (mode),
        .b_ext     (add_ext),
        .sum       (add_sum),
        .ovf       (add_ovf)
    );

    // NOTE: every register, including the result holding register, is reset
    // so a reset mid-sequence leaves no stale partial sum or pending result.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r    <= IDLE;
            sum_r      <= '0;
            count_r    <= '0;
            ovf_r      <= 1'b0;
            signed_r   <= 1'b0;
            v_o        <= 1'b0;
            data_o     <= '0;
            overflow_o <= 1'b0;
            count_o    <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register here update
            // from pre-edge values, independent of statement order.
            if (accept) begin
                if (last_i) begin
                    state_r    <= IDLE;
                    sum_r      <= '0;
                    count_r    <= '0;
                    ovf_r      <= 1'b0;
                    data_o     <= add_sum;
                    overflow_o <= ovf_next;
                    count_o    <= count_next;
                end else begin
                    state_r  <= ACCUM;
                    sum_r    <= add_sum;
                    count_r  <= count_next;
                    ovf_r    <= ovf_next;
                    signed_r <= mode;
                end
            end

            if (accept && last_i) begin
                v_o <= 1'b1;
            end else if (yumi_i) begin
                v_o <= 1'b0;
            end
        end
    end

endmodule
